regfile_wr_arbiter: RTL
=======================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter LOCK_MAX, default 4: maximum consecutive locked writes per grant; legal range 2..7.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  3  per-requester write request valid; bit i is requester i.
REQ-005 SHALL have port req_lock  input  3  per-requester request to hold the grant after this write.
REQ-006 SHALL have ports req_addr0/1/2  input  3 each  target register index for requesters 0/1/2.
REQ-007 SHALL have ports req_data0/1/2  input  8 each  write data for requesters 0/1/2.
REQ-008 SHALL have port req_ready  output  3  per-requester accept; combinational; at most one bit set.
REQ-009 SHALL have port w  output  1  register-file write enable; registered.
REQ-010 SHALL have port sw  output  3  register-file write select; registered.
REQ-011 SHALL have port c_in  output  8  register-file write data; registered.
REQ-012 SHALL have port gnt_id  output  2  index of the requester whose write is on w/sw/c_in; registered.
REQ-013 SHALL have port busy  output  1  high while state is LOCKED; registered.

Function
REQ-014 SHALL treat a transfer on requester i as req_valid[i] && req_ready[i] in the same cycle.
REQ-015 SHALL implement FSM states IDLE and LOCKED, plus a 2-bit round-robin pointer ptr (values 0..2), a 2-bit owner, and a 3-bit lock_cnt.
REQ-016 In IDLE, req_ready SHALL go to the first valid requester scanning ptr, ptr+1, ptr+2 (mod 3); with no valid requester, req_ready=000.
REQ-017 On an IDLE transfer by winner k with req_lock[k]=0, the FSM SHALL stay IDLE and set ptr=(k+1) mod 3.
REQ-018 On an IDLE transfer by winner k with req_lock[k]=1, the FSM SHALL enter LOCKED with owner=k and lock_cnt=1; ptr is unchanged.
REQ-019 In LOCKED, req_ready SHALL equal req_valid[owner] for the owner bit and 0 for all other bits.
REQ-020 In LOCKED, an owner transfer with req_lock=1 and lock_cnt+1<LOCK_MAX SHALL increment lock_cnt and keep LOCKED.
REQ-021 In LOCKED, the FSM SHALL go to IDLE with ptr=(owner+1) mod 3 on: an owner transfer with req_lock=0; an owner transfer bringing lock_cnt+1 to LOCK_MAX; or a cycle with req_valid[owner]=0.
REQ-022 Latency SHALL be one cycle: the cycle after a transfer, w=1, sw=req_addrK, c_in=req_dataK, gnt_id=K.
REQ-023 In a cycle after a non-transfer cycle, w SHALL be 0 and sw/c_in/gnt_id SHALL hold their previous values.
REQ-024 Back-to-back transfers SHALL be sustained at one write per cycle with no bubble.
REQ-025 Requests whose valid is dropped before transfer SHALL be discarded and SHALL produce no write.

Reset
REQ-026 On reset, the block SHALL set: state=IDLE, ptr=0, owner=0, lock_cnt=0, w=0, sw=000, c_in=00h, gnt_id=00, busy=0.
REQ-027 Reset SHALL take priority over every transfer; reset during LOCKED SHALL abandon the lock, and a transfer in the reset cycle SHALL NOT produce a write.

Configuration
REQ-028 With macro WR_CONFLICT_CNT_EN defined, the block SHALL add output conflict_cnt (8 bits). The counter SHALL increment in every cycle where a requester with valid=1 has ready=0, SHALL saturate at FFh, and SHALL reset to 00h.
REQ-029 Without WR_CONFLICT_CNT_EN, the port and the counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-030 After reset, drive req_valid=111 with lock=000 for 3 cycles -> req_ready=001,010,100 in turn, and gnt_id=0,1,2 one cycle later.
REQ-031 Drive only requester 1: valid, addr=5, data=A7h -> next cycle w=1, sw=5, c_in=A7h, gnt_id=1; the following idle cycle has w=0, sw=5, c_in=A7h.
REQ-032 With LOCK_MAX=4, requester 2 holds lock=1 and valid=1 while requester 0 is valid -> 4 consecutive writes from 2, busy=1 during the lock, then requester 0 is granted and ptr=0.
REQ-033 During LOCKED with owner 0, deassert req_valid[0] for 1 cycle -> state returns to IDLE and requester 1, if valid, is granted in the next cycle.
REQ-034 Assert reset in the middle of a lock with a transfer in the same cycle -> next cycle w=0, busy=0, and req_ready follows IDLE priority from requester 0.
REQ-035 With WR_CONFLICT_CNT_EN defined, hold req_valid=011 for 300 cycles with lock=000 -> conflict_cnt=FFh and stays at FFh.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: three-requester round-robin arbiter for one register-file write port,
//    with optional per-grant locking for up to LOCK_MAX consecutive writes by one requester.
// Latency: one cycle from an accepted request (req_valid & req_ready) to the w/sw/c_in/gnt_id write.
// Backpressure: req_ready is combinational, with at most one bit set; a requester that is not
//    ready simply holds its valid. A request dropped before it is accepted is discarded.
// Ports:
//    clk, reset                    rising-edge clock; synchronous active-high reset
//    req_valid/req_lock[2:0]       per-requester valid, and hold-grant-after-this-write
//    req_addr0..2, req_data0..2    per-requester register index (3b) and write data (8b)
//    req_ready[2:0]                per-requester accept (combinational)
//    w, sw, c_in, gnt_id           registered write enable, select, data and winning requester
//    busy                          registered, high while a lock is held
//    conflict_cnt                  only with WR_CONFLICT_CNT_EN defined: saturating 8-bit count of
//                                  cycles in which some valid requester was not ready
module regfile_wr_arbiter #(
   parameter int LOCK_MAX = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] req_valid,
   input  logic [2:0] req_lock,
   input  logic [2:0] req_addr0,
   input  logic [2:0] req_addr1,
   input  logic [2:0] req_addr2,
   input  logic [7:0] req_data0,
   input  logic [7:0] req_data1,
   input  logic [7:0] req_data2,
   output logic [2:0] req_ready,
   output logic       w,
   output logic [2:0] sw,
   output logic [7:0] c_in,
   output logic [1:0] gnt_id,
`ifdef WR_CONFLICT_CNT_EN
   output logic [7:0] conflict_cnt,
`endif
   output logic       busy
);

   typedef enum logic {IDLE, LOCKED} state_t;

   localparam logic [3:0] LMAX = 4'(LOCK_MAX);

   state_t     state, state_nxt;
   logic [1:0] ptr, ptr_nxt;
   logic [1:0] owner, owner_nxt;
   logic [2:0] lock_cnt, lock_cnt_nxt;
   logic [1:0] c0, c1, c2;
   logic [1:0] win;
   logic       win_vld;
   logic       xfer;
   logic [1:0] xfer_id;
   logic [2:0] addr_sel;
   logic [7:0] data_sel;

   function automatic logic [1:0] inc3(input logic [1:0] i);
      return (i == 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

   // Round-robin scan order: ptr, ptr+1, ptr+2 (mod 3).
   always_comb begin
      c0      = ptr;
      c1      = inc3(ptr);
      c2      = inc3(c1);
      win     = 2'd0;
      win_vld = 1'b0;
      if (req_valid[c0]) begin
         win = c0; win_vld = 1'b1;
      end else if (req_valid[c1]) begin
         win = c1; win_vld = 1'b1;
      end else if (req_valid[c2]) begin
         win = c2; win_vld = 1'b1;
      end
   end

   always_comb begin
      state_nxt    = state;
      ptr_nxt      = ptr;
      owner_nxt    = owner;
      lock_cnt_nxt = lock_cnt;
      req_ready    = 3'b000;
      xfer         = 1'b0;
      xfer_id      = 2'd0;
      case (state)
         IDLE: begin
            if (win_vld) begin
               req_ready = 3'b001 << win;
               xfer      = 1'b1;
               xfer_id   = win;
               if (req_lock[win]) begin
                  // Pointer stays put while locked; it advances past the owner on unlock.
                  state_nxt    = LOCKED;
                  owner_nxt    = win;
                  lock_cnt_nxt = 3'd1;
               end else begin
                  ptr_nxt = inc3(win);
               end
            end
         end
         LOCKED: begin
            req_ready = {2'b00, req_valid[owner]} << owner;
            if (req_valid[owner]) begin
               xfer    = 1'b1;
               xfer_id = owner;
            end
            // Stay locked only on an owner write that asks for more and has budget left.
            if (req_valid[owner] && req_lock[owner] && ({1'b0, lock_cnt} + 4'd1 < LMAX)) begin
               lock_cnt_nxt = lock_cnt + 3'd1;
            end else begin
               state_nxt    = IDLE;
               ptr_nxt      = inc3(owner);
               lock_cnt_nxt = 3'd0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      addr_sel = req_addr0;
      data_sel = req_data0;
      case (xfer_id)
         2'd1:    begin addr_sel = req_addr1; data_sel = req_data1; end
         2'd2:    begin addr_sel = req_addr2; data_sel = req_data2; end
         default: begin addr_sel = req_addr0; data_sel = req_data0; end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         ptr      <= 2'd0;
         owner    <= 2'd0;
         lock_cnt <= 3'd0;
         w        <= 1'b0;
         sw       <= 3'd0;
         c_in     <= 8'h00;
         gnt_id   <= 2'd0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         owner    <= owner_nxt;
         lock_cnt <= lock_cnt_nxt;
         busy     <= (state_nxt == LOCKED);
         w        <= xfer;
         if (xfer) begin
            sw     <= addr_sel;
            c_in   <= data_sel;
            gnt_id <= xfer_id;
         end
      end
   end

`ifdef WR_CONFLICT_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         conflict_cnt <= 8'h00;
      end else if (|(req_valid & ~req_ready) && (conflict_cnt != 8'hFF)) begin
         conflict_cnt <= conflict_cnt + 8'h01;
      end
   end
`endif

endmodule
